// File: rtl/calc_requester.sv
`default_nettype none
// ============================================================================
// calc_requester : FIFO-buffered host driver for the start/busy compute unit.
// Optional busy watchdog: define CALC_REQUESTER_TIMEOUT_EN.   Rev 1.0
// ============================================================================
module calc_requester #(
   parameter int DEPTH          = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       cmd_valid_i,
   output logic                       cmd_ready_o,
   input  logic [7:0]                 cmd_a_i,
   input  logic [7:0]                 cmd_b_i,
   output logic                       start_o,
   output logic [7:0]                 a_o,
   output logic [7:0]                 b_o,
   input  logic                       busy_i,
   input  logic [15:0]                y_i,
   output logic                       res_valid_o,
   input  logic                       res_ready_i,
   output logic [15:0]                res_y_o,
   output logic                       res_err_o,
   output logic [$clog2(DEPTH+1)-1:0] pending_o,
   output logic                       idle_o
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH + 1);

   if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0)) begin : g_bad_depth
      $error("calc_requester: DEPTH must be a power of two >= 2");
   end
   if ((TIMEOUT_CYCLES < 1) || (TIMEOUT_CYCLES > 65535)) begin : g_bad_timeout
      $error("calc_requester: TIMEOUT_CYCLES must be in 1..65535");
   end

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_ISSUE  = 3'd1,
      S_WAIT   = 3'd2,
      S_SETTLE = 3'd3,
      S_OUT    = 3'd4
   } state_t;

   state_t          state_q, state_d;
   logic [7:0]      mem_a_q [DEPTH];
   logic [7:0]      mem_b_q [DEPTH];
   logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   count_q;
   logic            push, pop;

   logic            start_q, start_d;
   logic [7:0]      a_q, a_d, b_q, b_d;
   logic            res_valid_q, res_valid_d;
   logic [15:0]     res_y_q, res_y_d;
`ifdef CALC_REQUESTER_TIMEOUT_EN
   logic            res_err_q, res_err_d;
   logic [15:0]     tmo_q, tmo_d;
`endif

   assign cmd_ready_o = (count_q != CW'(DEPTH));
   assign push        = cmd_valid_i && cmd_ready_o;
   assign pending_o   = count_q;
   assign idle_o      = (count_q == '0) && (state_q == S_IDLE);

   // Storage needs no reset; occupancy is tracked by the pointers and count.
   always_ff @(posedge clk_i) begin
      if (push) begin
         mem_a_q[wr_ptr_q] <= cmd_a_i;
         mem_b_q[wr_ptr_q] <= cmd_b_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
         if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
         if (push && !pop)      count_q <= count_q + CW'(1);
         else if (pop && !push) count_q <= count_q - CW'(1);
      end
   end

   always_comb begin
      state_d     = state_q;
      pop         = 1'b0;
      start_d     = 1'b0;
      a_d         = a_q;
      b_d         = b_q;
      res_valid_d = res_valid_q;
      res_y_d     = res_y_q;
`ifdef CALC_REQUESTER_TIMEOUT_EN
      res_err_d   = res_err_q;
      tmo_d       = tmo_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (count_q != '0) begin
               pop     = 1'b1;
               a_d     = mem_a_q[rd_ptr_q];
               b_d     = mem_b_q[rd_ptr_q];
               start_d = 1'b1;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
`ifdef CALC_REQUESTER_TIMEOUT_EN
            tmo_d   = '0;
`endif
            state_d = S_WAIT;
         end
         S_WAIT: begin
`ifdef CALC_REQUESTER_TIMEOUT_EN
            tmo_d = tmo_q + 16'd1;
            if (!busy_i) begin
               state_d = S_SETTLE;
            end else if (tmo_q == 16'(TIMEOUT_CYCLES - 1)) begin
               // Abandon the unit: a later busy fall lands in IDLE and is ignored.
               res_y_d     = '0;
               res_err_d   = 1'b1;
               res_valid_d = 1'b1;
               state_d     = S_OUT;
            end
`else
            if (!busy_i) state_d = S_SETTLE;
`endif
         end
         S_SETTLE: begin
            res_y_d     = y_i;
`ifdef CALC_REQUESTER_TIMEOUT_EN
            res_err_d   = 1'b0;
`endif
            res_valid_d = 1'b1;
            state_d     = S_OUT;
         end
         S_OUT: begin
            if (res_ready_i) begin
               res_valid_d = 1'b0;
               state_d     = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         state_q     <= S_IDLE;
         start_q     <= 1'b0;
         a_q         <= '0;
         b_q         <= '0;
         res_valid_q <= 1'b0;
         res_y_q     <= '0;
`ifdef CALC_REQUESTER_TIMEOUT_EN
         res_err_q   <= 1'b0;
         tmo_q       <= '0;
`endif
      end else begin
         state_q     <= state_d;
         start_q     <= start_d;
         a_q         <= a_d;
         b_q         <= b_d;
         res_valid_q <= res_valid_d;
         res_y_q     <= res_y_d;
`ifdef CALC_REQUESTER_TIMEOUT_EN
         res_err_q   <= res_err_d;
         tmo_q       <= tmo_d;
`endif
      end
   end

   assign start_o     = start_q;
   assign a_o         = a_q;
   assign b_o         = b_q;
   assign res_valid_o = res_valid_q;
   assign res_y_o     = res_y_q;
`ifdef CALC_REQUESTER_TIMEOUT_EN
   assign res_err_o   = res_err_q;
`else
   assign res_err_o   = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_calc_requester.sv
`default_nettype none
// ============================================================================
// tb_calc_requester : directed scoreboard bench for calc_requester.
// Rev 1.0
// ============================================================================
module tb_calc_requester;

   localparam int DEPTH = 4;
   localparam int TMO   = 10;
   localparam int CW    = $clog2(DEPTH + 1);

   logic          clk_i       = 1'b0;
   logic          rst_i       = 1'b0;
   logic          cmd_valid_i = 1'b0;
   logic [7:0]    cmd_a_i     = '0;
   logic [7:0]    cmd_b_i     = '0;
   logic          busy_i      = 1'b0;
   logic [15:0]   y_i         = '0;
   logic          res_ready_i = 1'b0;
   logic          cmd_ready_o, start_o, res_valid_o, res_err_o, idle_o;
   logic [7:0]    a_o, b_o;
   logic [15:0]   res_y_o;
   logic [CW-1:0] pending_o;

   calc_requester #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
      .cmd_a_i(cmd_a_i), .cmd_b_i(cmd_b_i),
      .start_o(start_o), .a_o(a_o), .b_o(b_o),
      .busy_i(busy_i), .y_i(y_i),
      .res_valid_o(res_valid_o), .res_ready_i(res_ready_i),
      .res_y_o(res_y_o), .res_err_o(res_err_o),
      .pending_o(pending_o), .idle_o(idle_o)
   );

   always #5 clk_i = ~clk_i;

   int          n_vec = 0, n_err = 0;
   int          cyc = 0;
   logic [16:0] exp_q [$];
   int          start_cyc_q [$];
   int          n_start = 0, n_res = 0;
   int          fall_cyc = -1, rise_cyc = -1;
   logic        busy_prev = 1'b0, rv_prev = 1'b0;
   logic [7:0]  st_a = '0, st_b = '0;
   logic [16:0] sb_e;
   int          model_n = 0;
   bit          model_hold = 1'b0, yovr_en = 1'b0, tmo_mode = 1'b0;
   logic [15:0] yovr = '0;
   int          m_cnt = 0;
   logic [15:0] m_res = '0;

   function automatic logic [15:0] ref_y(input logic [7:0] a, input logic [7:0] b);
      return yovr_en ? yovr : (16'(a) * 16'(b));
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   always @(posedge clk_i) cyc <= cyc + 1;

   // Compute-unit model: busy for model_n cycles after start, result after busy falls.
   always @(posedge clk_i) begin
      if (start_o) begin
         m_res <= ref_y(a_o, b_o);
         m_cnt <= model_n;
         if (model_n > 0 || model_hold) begin
            busy_i <= 1'b1;
            y_i    <= 16'hBAD0;
         end else begin
            y_i    <= ref_y(a_o, b_o);
         end
      end else if (busy_i) begin
         if (!model_hold && m_cnt <= 1) begin
            busy_i <= 1'b0;
            y_i    <= m_res;
         end else begin
            m_cnt  <= m_cnt - 1;
         end
      end
   end

   always @(negedge clk_i) begin
      if (rst_i) begin
         if (cmd_valid_i && cmd_ready_o)
            exp_q.push_back(tmo_mode ? 17'h10000 : {1'b0, ref_y(cmd_a_i, cmd_b_i)});
         if (start_o) begin
            n_start++;
            start_cyc_q.push_back(cyc);
            st_a = a_o;
            st_b = b_o;
         end
         if (busy_prev && !busy_i) fall_cyc = cyc;
         if (res_valid_o && !rv_prev) rise_cyc = cyc;
         if (res_valid_o && res_ready_i) begin
            n_res++;
            n_vec++;
            assert (exp_q.size() > 0) else begin
               n_err++;
               $error("FAIL res_unexpected: observed y=%0h with no expected entry", res_y_o);
            end
            if (exp_q.size() > 0) begin
               sb_e = exp_q.pop_front();
               chk("res_y", 32'(res_y_o), 32'(sb_e[15:0]));
               chk("res_err", 32'(res_err_o), 32'(sb_e[16]));
            end
         end
      end
      busy_prev = busy_i;
      rv_prev   = res_valid_o;
   end

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   task automatic push(input logic [7:0] a, input logic [7:0] b);
      int k = 0;
      cmd_valid_i = 1'b1;
      cmd_a_i     = a;
      cmd_b_i     = b;
      while (!cmd_ready_o && k < 200) begin
         tick();
         k++;
      end
      tick();
      cmd_valid_i = 1'b0;
      chk("push_accepted", 32'(k < 200), 32'd1);
   endtask

   task automatic wait_idle(input string tag);
      int k = 0;
      while (!(idle_o && !busy_i && !res_valid_o) && k < 2000) begin
         tick();
         k++;
      end
      chk(tag, 32'(k < 2000), 32'd1);
   endtask

   initial begin
      #500000;
      $display("FAIL global_timeout: simulation did not finish");
      $fatal(1, "global timeout");
   end

   initial begin
      int s0, r0, k, seen;

      // Reset state
      rst_i = 1'b0;
      repeat (3) tick();
      chk("rst_start", 32'(start_o), 32'd0);
      chk("rst_a", 32'(a_o), 32'd0);
      chk("rst_b", 32'(b_o), 32'd0);
      chk("rst_res_valid", 32'(res_valid_o), 32'd0);
      chk("rst_res_y", 32'(res_y_o), 32'd0);
      chk("rst_res_err", 32'(res_err_o), 32'd0);
      chk("rst_pending", 32'(pending_o), 32'd0);
      chk("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
      chk("rst_idle", 32'(idle_o), 32'd1);
      rst_i = 1'b1;
      tick();

      // Single command, 6-cycle busy, fixed result 15
      res_ready_i = 1'b1;
      model_n = 6;
      yovr = 16'd15;
      yovr_en = 1'b1;
      s0 = n_start;
      push(8'd5, 8'd27);
      wait_idle("t1_done");
      chk("t1_start_count", 32'(n_start - s0), 32'd1);
      chk("t1_a", 32'(st_a), 32'd5);
      chk("t1_b", 32'(st_b), 32'd27);
      chk("t1_valid_after_fall", 32'(rise_cyc - fall_cyc), 32'd2);
      yovr_en = 1'b0;

      // Fill the FIFO behind a stalled result
      res_ready_i = 1'b0;
      model_n = 2;
      s0 = n_start;
      r0 = n_res;
      for (int i = 0; i < 5; i++) push(8'(i + 1), 8'(i + 16));
      chk("t2_pending_full", 32'(pending_o), 32'd4);
      chk("t2_cmd_ready_full", 32'(cmd_ready_o), 32'd0);
      cmd_valid_i = 1'b1;
      cmd_a_i = 8'd99;
      cmd_b_i = 8'd99;
      repeat (3) tick();
      cmd_valid_i = 1'b0;
      chk("t2_pending_after_drop", 32'(pending_o), 32'd4);
      chk("t2_one_issued", 32'(n_start - s0), 32'd1);
      res_ready_i = 1'b1;
      wait_idle("t2_done");
      chk("t2_results", 32'(n_res - r0), 32'd5);

      // Zero-busy streaming: start every 5 cycles
      model_n = 0;
      start_cyc_q.delete();
      push(8'd7, 8'd3);
      push(8'd200, 8'd201);
      push(8'd255, 8'd255);
      wait_idle("t3_done");
      chk("t3_starts", 32'(start_cyc_q.size()), 32'd3);
      chk("t3_gap0", 32'(start_cyc_q[1] - start_cyc_q[0]), 32'd5);
      chk("t3_gap1", 32'(start_cyc_q[2] - start_cyc_q[1]), 32'd5);

      // Reset during WAIT with two commands queued
      model_n = 20;
      push(8'd11, 8'd12);
      push(8'd13, 8'd14);
      push(8'd15, 8'd16);
      k = 0;
      while (!busy_i && k < 100) begin
         tick();
         k++;
      end
      chk("t4_reached_wait", 32'(busy_i), 32'd1);
      chk("t4_pending_before", 32'(pending_o), 32'd2);
      rst_i = 1'b0;
      exp_q.delete();
      repeat (2) tick();
      chk("t4_pending_rst", 32'(pending_o), 32'd0);
      chk("t4_res_valid_rst", 32'(res_valid_o), 32'd0);
      rst_i = 1'b1;
      s0 = n_start;
      r0 = n_res;
      repeat (40) tick();
      chk("t4_no_start", 32'(n_start - s0), 32'd0);
      chk("t4_no_result", 32'(n_res - r0), 32'd0);
      chk("t4_idle", 32'(idle_o), 32'd1);

      // Simultaneous push and pop at pending=2
      res_ready_i = 1'b0;
      model_n = 0;
      push(8'd3, 8'd4);
      push(8'd5, 8'd6);
      push(8'd7, 8'd8);
      k = 0;
      while (!res_valid_o && k < 100) begin
         tick();
         k++;
      end
      chk("t5_pending_pre", 32'(pending_o), 32'd2);
      res_ready_i = 1'b1;
      tick();
      res_ready_i = 1'b0;
      cmd_valid_i = 1'b1;
      cmd_a_i = 8'd9;
      cmd_b_i = 8'd10;
      chk("t5_pending_pushpop_cycle", 32'(pending_o), 32'd2);
      tick();
      cmd_valid_i = 1'b0;
      chk("t5_pending_after", 32'(pending_o), 32'd2);
      chk("t5_issue", 32'(start_o), 32'd1);
      chk("t5_issue_a", 32'(a_o), 32'd5);
      res_ready_i = 1'b1;
      wait_idle("t5_done");

`ifdef CALC_REQUESTER_TIMEOUT_EN
      // Watchdog: busy never falls
      model_hold = 1'b1;
      tmo_mode = 1'b1;
      start_cyc_q.delete();
      push(8'd9, 8'd9);
      tmo_mode = 1'b0;
      k = 0;
      seen = 0;
      while (!res_valid_o && k < 200) begin
         tick();
         k++;
      end
      seen = cyc;
      chk("t6_tmo_latency", 32'(seen - start_cyc_q[0]), 32'(TMO + 1));
      tick();
      model_hold = 1'b0;
      model_n = 1;
      s0 = n_start;
      push(8'd11, 8'd12);
      wait_idle("t6_done");
      chk("t6_next_issued", 32'(n_start - s0), 32'd1);
`endif

      chk("sb_drained", 32'(exp_q.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/calc_requester.md
# calc_requester

Host-side driver for the start/busy compute-unit protocol used by our arithmetic blocks: the unit samples operands while its start input is high, raises busy for the duration of the computation, and presents its 16-bit result one cycle after busy falls. `calc_requester` buffers operand pairs in a small FIFO and issues them to the unit one at a time. It collects each result and returns it on a valid/ready result port, so upstream logic never handles the busy handshake directly.

## Interface
Parameters:
- `DEPTH`, 4: command FIFO depth; power of two, minimum 2.
- `TIMEOUT_CYCLES`, 255: busy-wait limit used when the watchdog is compiled in; range 1..65535.

Ports:
- `clk_i`  in  1  single clock; all logic is on the rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  FIFO not full.
- `cmd_a_i`  in  8  operand a.
- `cmd_b_i`  in  8  operand b.
- `start_o`  out  1  one-cycle start pulse to the unit.
- `a_o`  out  8  operand a to the unit; registered.
- `b_o`  out  8  operand b to the unit; registered.
- `busy_i`  in  1  unit busy.
- `y_i`  in  16  unit result.
- `res_valid_o`  out  1  result available.
- `res_ready_i`  in  1  result consumer ready.
- `res_y_o`  out  16  captured result.
- `res_err_o`  out  1  result produced by the watchdog, not by the unit.
- `pending_o`  out  $clog2(DEPTH+1)  number of queued commands.
- `idle_o`  out  1  FIFO empty and FSM in IDLE.

## Operation
- FIFO push: on a cycle where `cmd_valid_i && cmd_ready_o`.
- `cmd_ready_o`: equals `pending_o != DEPTH`.
- FIFO pointers wrap modulo DEPTH.
- FSM states: IDLE, ISSUE, WAIT, SETTLE, OUT.
- IDLE: if the FIFO is non-empty, load the head entry into `a_o`/`b_o`, pop it, and go to ISSUE.
- ISSUE: `start_o`=1 for exactly one cycle with `a_o`/`b_o` stable. `busy_i` is ignored in this cycle. Go to WAIT.
- WAIT: sample `busy_i`. If 0, go to SETTLE; otherwise stay in WAIT.
- SETTLE: one cycle. Capture `y_i` into `res_y_o`, clear `res_err_o`, and go to OUT.
- OUT: `res_valid_o`=1. `res_y_o` and `res_err_o` are held until `res_ready_i`=1, then go to IDLE.
- Only one command is outstanding at a time. No new ISSUE begins while a result is unconsumed.
- `a_o`/`b_o` hold their last issued values between commands.
- Push while full: ignored, because `cmd_ready_o`=0; the FIFO contents are unchanged.
- Push and pop in the same cycle: legal at any occupancy below full. `pending_o` is unchanged.
- `pending_o` counts FIFO entries only; the command in flight is not counted.
- Reset asserted at any time, including mid-computation: the FIFO is emptied and the FSM goes to IDLE. The unit is not aborted; its late result is ignored.
- Reset values: `start_o`=0, `a_o`=0, `b_o`=0, `res_valid_o`=0, `res_y_o`=0, `res_err_o`=0, `pending_o`=0, `cmd_ready_o`=1, `idle_o`=1.

## Timing
- Example sequence, with a command pushed into an empty FIFO at cycle 0:
  - Cycle 1: IDLE pops the command.
  - Cycle 2: `start_o`=1.
  - Cycle 3 onward: WAIT.
- If `busy_i` is first sampled low at cycle W, SETTLE is cycle W+1 and `res_valid_o` rises at cycle W+2.
- Minimum latency, from push to `res_valid_o`, is 5 cycles (with `busy_i` low at cycle 3).
- Back-to-back commands: the next `start_o` comes 2 cycles after the result handshake. The handshake cycle is followed by IDLE, then ISSUE.
- All outputs are registered except `cmd_ready_o` and `idle_o`, which are decoded from state registers only.

## Configuration
- `CALC_REQUESTER_TIMEOUT_EN` defined:
  - A 16-bit counter clears on entry to WAIT and increments every WAIT cycle.
  - If it reaches `TIMEOUT_CYCLES` while `busy_i`=1, the FSM goes directly to OUT with `res_y_o`=0 and `res_err_o`=1.
  - Any later `busy_i` fall from that command is ignored.
- Not defined: no counter is present, WAIT is unbounded, and `res_err_o` is tied to 0.

## Test plan
- After reset, push (a=5, b=27) with the unit model busy for 6 cycles and returning y=15 -> `start_o` pulses exactly once with a_o=5, b_o=27; `res_valid_o` rises 2 cycles after busy falls with `res_y_o`=15 and `res_err_o`=0.
- Push 5 commands with `res_ready_i`=0 and DEPTH=4 -> the first is issued, the FIFO then fills, and `cmd_ready_o`=0 once `pending_o`=4. The 6th push is dropped; releasing `res_ready_i` returns all 5 results in order.
- With the unit busy for 0 cycles after start, stream 3 commands with `res_ready_i`=1 -> each start is 5 cycles after the previous one and results arrive in order.
- Assert reset during WAIT with 2 commands queued, then release -> `pending_o`=0, `res_valid_o`=0, and no further `start_o`. Busy falling after release produces no result.
- With the macro defined and TIMEOUT_CYCLES=10, hold `busy_i`=1 forever -> OUT is reached after 10 WAIT cycles with `res_y_o`=0 and `res_err_o`=1; the next command issues normally.
- Push and pop in the same cycle at `pending_o`=2 -> `pending_o` stays 2 and the FIFO order is preserved.
